// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and default parameters for the CPU run monitor.
// Includes the state encoding used by the controller FSM.
package cpu_run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } run_state_t;

    localparam int DEF_NUM_CORES      = 1;
    localparam int DEF_CNT_WIDTH      = 32;
    localparam int DEF_TIMEOUT_CYCLES = 500000;

endpackage

// File: rtl/cpu_run_monitor_capture.sv
// Per-core sticky finished flag plus finish-cycle capture register.
// Built only when CPU_RUN_MONITOR_CAPTURE_EN is defined.
module cpu_run_capture
    import cpu_run_monitor_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk_sys,
    input  logic                 rst_b,
    input  logic                 clear,
    input  logic                 sample,
    input  logic                 core_done,
    input  logic [CNT_WIDTH-1:0] count,
    output logic                 done_flag,
    output logic [CNT_WIDTH-1:0] cycles
);

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            done_flag <= 1'b0;
            cycles    <= '0;
        end else if (clear) begin
            done_flag <= 1'b0;
            cycles    <= '0;
        end else if (sample && core_done && !done_flag) begin
            // first assertion wins; later edges of core_done are ignored
            done_flag <= 1'b1;
            cycles    <= count;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller and watchdog for NUM_CORES CPU cores.
// Optional macro CPU_RUN_MONITOR_CAPTURE_EN builds the per-core finish-cycle registers.
//
// state | meaning
// IDLE  | waiting for START, results of an aborted run held
// RUN   | cores enabled, cycle counter advancing, finishes captured
// DONE  | every core finished, results held
// FAIL  | cycle budget expired before all cores finished, results held
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int NUM_CORES      = DEF_NUM_CORES,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           MAIN_CLOCK,
    input  logic                           MAIN_RESET_N,
    input  logic                           START,
    input  logic                           ABORT,
    input  logic [NUM_CORES-1:0]           CORE_DONE,
    output logic                           CORE_RUN,
    output logic                           BUSY,
    output logic                           ALL_DONE,
    output logic                           TIMEOUT,
    output logic [NUM_CORES-1:0]           DONE_MASK,
    output logic [CNT_WIDTH-1:0]           CYCLE_COUNT,
    output logic [NUM_CORES*CNT_WIDTH-1:0] CORE_CYCLES
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    run_state_t           state_r;
    logic                 start_go;
    logic                 cap_en;
    logic [NUM_CORES-1:0] mask_upd;
    logic                 all_set;
    logic                 at_limit;
    logic [CNT_WIDTH-1:0] count_inc;

    always_comb begin
        start_go  = START && (state_r != ST_RUN);
        cap_en    = (state_r == ST_RUN) && !ABORT;
        mask_upd  = DONE_MASK | (CORE_DONE & {NUM_CORES{cap_en}});
        all_set   = &mask_upd;
        at_limit  = (CYCLE_COUNT == LIMIT);
        count_inc = (&CYCLE_COUNT) ? CYCLE_COUNT : CYCLE_COUNT + CNT_WIDTH'(1);
    end

    always_ff @(posedge MAIN_CLOCK) begin
        if (!MAIN_RESET_N) begin
            state_r     <= ST_IDLE;
            CORE_RUN    <= 1'b0;
            BUSY        <= 1'b0;
            ALL_DONE    <= 1'b0;
            TIMEOUT     <= 1'b0;
            CYCLE_COUNT <= '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (ABORT) begin
                        state_r  <= ST_IDLE;
                        CORE_RUN <= 1'b0;
                        BUSY     <= 1'b0;
                    end else if (all_set) begin
                        // completion beats the budget on the same edge
                        state_r     <= ST_DONE;
                        CORE_RUN    <= 1'b0;
                        BUSY        <= 1'b0;
                        ALL_DONE    <= 1'b1;
                        CYCLE_COUNT <= count_inc;
                    end else if (at_limit) begin
                        // count is left on the last budget cycle it reached
                        state_r  <= ST_FAIL;
                        CORE_RUN <= 1'b0;
                        BUSY     <= 1'b0;
                        TIMEOUT  <= 1'b1;
                    end else begin
                        CYCLE_COUNT <= count_inc;
                    end
                end
                default: begin
                    if (START) begin
                        state_r     <= ST_RUN;
                        CORE_RUN    <= 1'b1;
                        BUSY        <= 1'b1;
                        ALL_DONE    <= 1'b0;
                        TIMEOUT     <= 1'b0;
                        CYCLE_COUNT <= '0;
                    end
                end
            endcase
        end
    end

`ifdef CPU_RUN_MONITOR_CAPTURE_EN
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        cpu_run_capture #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_capture (
            .clk_sys   (MAIN_CLOCK),
            .rst_b     (MAIN_RESET_N),
            .clear     (start_go),
            .sample    (cap_en),
            .core_done (CORE_DONE[g]),
            .count     (CYCLE_COUNT),
            .done_flag (DONE_MASK[g]),
            .cycles    (CORE_CYCLES[g*CNT_WIDTH +: CNT_WIDTH])
        );
    end
`else
    always_ff @(posedge MAIN_CLOCK) begin
        if (!MAIN_RESET_N) begin
            DONE_MASK <= '0;
        end else if (start_go) begin
            DONE_MASK <= '0;
        end else begin
            DONE_MASK <= mask_upd;
        end
    end

    assign CORE_CYCLES = '0;
`endif

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable run controller and watchdog for one or more matrix-multiplication CPU cores. It issues a run enable, counts clock cycles while the cores execute, and records the cycle on which each core's PROCESS_DONE first asserts. It flags completion when every core has finished, or a timeout when a fixed cycle budget expires. It sits between board or bench start logic and the CPU instances, and replaces the fixed-delay end-of-simulation approach with a measured, checkable completion.

## Interface
- NUM_CORES, 1, number of monitored cores (1..16)
- CNT_WIDTH, 32, width of all cycle counters
- TIMEOUT_CYCLES, 500000, cycle budget per run (8 ms at a 16 ns clock); must be ≤ 2^CNT_WIDTH−1
- MAIN_CLOCK  in  1  single system clock, rising edge
- MAIN_RESET_N  in  1  synchronous, active-low reset
- START  in  1  pulse; begins a run
- ABORT  in  1  pulse; ends a run without completion
- CORE_DONE  in  NUM_CORES  per-core PROCESS_DONE levels
- CORE_RUN  out  1  run enable to all cores
- BUSY  out  1  high in RUN
- ALL_DONE  out  1  high in DONE
- TIMEOUT  out  1  high in FAIL
- DONE_MASK  out  NUM_CORES  sticky per-core finished flags
- CYCLE_COUNT  out  CNT_WIDTH  cycles elapsed in the current or last run
- CORE_CYCLES  out  NUM_CORES*CNT_WIDTH  per-core finish cycle; core i occupies bits [i*CNT_WIDTH +: CNT_WIDTH]

## Operation
- States: IDLE, RUN, DONE, FAIL. Reset goes to IDLE, and every output is 0.
- IDLE, DONE, or FAIL with START=1 → RUN. The same edge clears CYCLE_COUNT, DONE_MASK, and CORE_CYCLES.
- In RUN:
  - CORE_RUN=1 and BUSY=1.
  - CYCLE_COUNT increments by 1 each cycle and saturates at all-ones.
  - Each cycle, for each i with CORE_DONE[i]=1 and DONE_MASK[i]=0: set DONE_MASK[i] and capture the current CYCLE_COUNT into slot i.
  - CORE_DONE is level-sampled. Deassertion after capture is ignored.
- RUN → DONE when the updated mask is all ones. Bits set on the current edge count toward this.
- RUN → FAIL when CYCLE_COUNT = TIMEOUT_CYCLES−1 and the mask is not complete after this cycle's update.
- If the last core finishes on the timeout cycle, DONE wins.
- RUN with ABORT=1 → IDLE. Counters and mask keep their values. No capture happens on that edge.
- ABORT has priority over completion and timeout on the same edge.
- START in RUN is ignored. ABORT outside RUN is ignored. If START and ABORT are both high, ABORT wins in RUN and START wins elsewhere.
- DONE and FAIL hold all results until the next START or reset.

## Timing
- All outputs are registered.
- START sampled at edge k → CORE_RUN=1 and CYCLE_COUNT=0 after edge k.
- CORE_DONE[i] high before edge m → DONE_MASK[i]=1 after edge m. Slot i then holds the CYCLE_COUNT value from before edge m.
- Completion or timeout edge → ALL_DONE or TIMEOUT=1, and CORE_RUN=0, on the same edge. Latency is zero extra cycles.
- Reset is synchronous. MAIN_RESET_N=0 mid-run clears every output at the next edge.
- Minimum run length is 1 cycle. A CORE_DONE already high when START is sampled is captured with CORE_CYCLES=0.

## Configuration
- CPU_RUN_MONITOR_CAPTURE_EN:
  - Defined: the per-core CORE_CYCLES capture registers are built.
  - Undefined: CORE_CYCLES is tied to 0, no capture registers exist, and DONE_MASK, state, and CYCLE_COUNT behave identically.

## Structure
- Shared package holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2, FAIL=2'd3
  - default NUM_CORES, CNT_WIDTH, and TIMEOUT_CYCLES values
- One sub-module, cpu_run_capture: a single core's sticky flag plus capture register, instantiated NUM_CORES times in a generate loop. It is omitted when the macro is undefined, leaving only the flag.

## Test plan
- NUM_CORES=1, START at cycle 2, CORE_DONE rises 100 cycles after CORE_RUN → ALL_DONE=1, CORE_CYCLES=100, CYCLE_COUNT=101, CORE_RUN=0.
- NUM_CORES=4, TIMEOUT_CYCLES=1000, cores finish at counts 10, 50, 50, 300 → DONE_MASK progresses 0001, 0111, 1111. CORE_CYCLES are {10,50,50,300}. ALL_DONE at count 300.
- TIMEOUT_CYCLES=64, core 1 never finishes → TIMEOUT=1 with CYCLE_COUNT=63, DONE_MASK=0b01, ALL_DONE=0.
- TIMEOUT_CYCLES=64, last core done exactly at count 63 → ALL_DONE=1 and TIMEOUT=0.
- ABORT at count 20 → IDLE, BUSY=0, CYCLE_COUNT=20. A following START clears everything, and the rerun completes normally.
- MAIN_RESET_N low at count 37 of a run → every output is 0 the next cycle. START during RUN changes nothing. Rerun with the macro undefined → CORE_CYCLES stays 0.
